// File: rtl/pc_sequencer_if.sv
// Next-PC stage bus: retire/branch controls and ALU flags in, PC/flags/stack status out.
interface pc_sequencer_if;
  logic        step;
  logic [3:0]  pc_control;
  logic [25:0] offset;
  logic [31:0] reg_target;
  logic        flag_wren;
  logic        alu_z;
  logic        alu_c;
  logic        alu_s;
  logic        alu_v;
  logic [31:0] pc;
  logic [3:0]  flags;
  logic        taken;
  logic [5:0]  stack_depth;
  logic        stack_err;

  // Decoder/ALU side that drives the sequencer
  modport master (
    output step, pc_control, offset, reg_target, flag_wren, alu_z, alu_c, alu_s, alu_v,
    input  pc, flags, taken, stack_depth, stack_err
  );

  // The sequencer itself
  modport slave (
    input  step, pc_control, offset, reg_target, flag_wren, alu_z, alu_c, alu_s, alu_v,
    output pc, flags, taken, stack_depth, stack_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC stage: PC register, {Z,C,S,V} flag register and hardware return-address stack.
// Branch conditions use the registered flags, so a branch that also writes flags sees the old ones.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          STACK_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);
  localparam int         AW        = $clog2(STACK_DEPTH);
  localparam logic [5:0] DEPTH_MAX = 6'(STACK_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [3:0]    flags_q, flags_d;
  logic [5:0]    sp_q, sp_d;
  logic          err_q, err_d;
  logic          push;
  logic          taken_c;
  logic [31:0]   next_pc;
  logic [31:0]   seq;
  logic [31:0]   tgt;
  logic [31:0]   top;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] pop_idx;

  // Small LIFO; the popped entry must be usable in the same cycle, so it is read combinationally.
  logic [31:0] stack_mem [STACK_DEPTH];

  assign seq      = pc_q + 32'd4;
  assign tgt      = seq + {{4{bus.offset[25]}}, bus.offset, 2'b00};
  assign push_idx = sp_q[AW-1:0];
  assign pop_idx  = push_idx - AW'(1);
  assign top      = stack_mem[pop_idx];

  // Decode the branch code, then commit PC/flags/stack only when an instruction retires.
  always_comb begin
    next_pc = seq;
    taken_c = 1'b0;
    push    = 1'b0;
    pc_d    = pc_q;
    flags_d = flags_q;
    sp_d    = sp_q;
    err_d   = err_q;

    case (bus.pc_control)
      4'd1:  begin next_pc = tgt;            taken_c = 1'b1; end
      4'd2:  begin next_pc = bus.reg_target; taken_c = 1'b1; end
      4'd3:  taken_c = flags_q[3];
      4'd4:  taken_c = ~flags_q[3];
      4'd5:  taken_c = flags_q[2];
      4'd6:  taken_c = ~flags_q[2];
      4'd7:  taken_c = flags_q[1];
      4'd8:  taken_c = ~flags_q[1];
      4'd9:  taken_c = flags_q[0];
      4'd10: taken_c = ~flags_q[0];
      4'd11: begin next_pc = tgt; taken_c = 1'b1; end
      4'd12: begin
        // An empty stack falls through to seq, so the PC is not redirected.
        if (sp_q != 6'd0) begin
          next_pc = top;
          taken_c = 1'b1;
        end
      end
      default: ;
    endcase

    if (bus.pc_control >= 4'd3 && bus.pc_control <= 4'd10 && taken_c) begin
      next_pc = tgt;
    end

    if (bus.step) begin
      pc_d = next_pc;
      if (bus.flag_wren) begin
        flags_d = {bus.alu_z, bus.alu_c, bus.alu_s, bus.alu_v};
      end
      if (bus.pc_control == 4'd11) begin
        if (sp_q == DEPTH_MAX) begin
          err_d = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + 6'd1;
        end
      end else if (bus.pc_control == 4'd12) begin
        if (sp_q == 6'd0) begin
          err_d = 1'b1;
        end else begin
          sp_d = sp_q - 6'd1;
        end
      end
    end
  end

  // Architectural state; reset wins over a retiring instruction and empties the stack.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      flags_q <= 4'd0;
      sp_q    <= 6'd0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Return-address write; stack contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      stack_mem[push_idx] <= seq;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.flags       = flags_q;
  assign bus.taken       = taken_c;
  assign bus.stack_depth = sp_q;
  assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: instance A (RESET_PC=0x100, 8-deep stack) and
// instance B (RESET_PC=0, 2-deep stack) driven by directed vectors.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus_a ();
  pc_sequencer_if bus_b ();

  pc_sequencer #(.RESET_PC(32'h100), .STACK_DEPTH(8)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  pc_sequencer #(.RESET_PC(32'h0), .STACK_DEPTH(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  typedef struct {
    bit          sel;
    bit          chk_taken;
    bit          taken;
    logic [31:0] pc;
    logic [3:0]  flags;
    logic [5:0]  depth;
    bit          err;
    string       name;
  } exp_t;

  exp_t q[$];
  bit   vld = 1'b0;
  bit   cur_sel = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Drive one transaction on the selected instance and queue what it must produce.
  task automatic vec(input bit sel, input bit r, input bit st, input logic [3:0] ctl,
                     input logic [25:0] off, input logic [31:0] rt, input logic [4:0] fzcsv,
                     input bit ct, input bit et, input logic [31:0] epc, input logic [3:0] ef,
                     input logic [5:0] ed, input bit ee, input string nm);
    exp_t e;
    @(negedge clk);
    bus_a.step = 1'b0; bus_b.step = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    if (sel == 1'b0) begin
      rst_a = r; bus_a.step = st; bus_a.pc_control = ctl; bus_a.offset = off;
      bus_a.reg_target = rt; {bus_a.flag_wren, bus_a.alu_z, bus_a.alu_c, bus_a.alu_s, bus_a.alu_v} = fzcsv;
    end else begin
      rst_b = r; bus_b.step = st; bus_b.pc_control = ctl; bus_b.offset = off;
      bus_b.reg_target = rt; {bus_b.flag_wren, bus_b.alu_z, bus_b.alu_c, bus_b.alu_s, bus_b.alu_v} = fzcsv;
    end
    cur_sel = sel;
    vld = 1'b1;
    e.sel = sel; e.chk_taken = ct; e.taken = et; e.pc = epc; e.flags = ef;
    e.depth = ed; e.err = ee; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: taken sampled just before the edge, registered outputs just after it.
  initial begin
    exp_t        e;
    bit          s_taken;
    bit          s_sel;
    logic [31:0] a_pc;
    logic [3:0]  a_fl;
    logic [5:0]  a_d;
    logic        a_e;
    forever begin
      @(negedge clk);
      #4;
      if (vld) begin
        s_sel   = cur_sel;
        s_taken = s_sel ? bus_b.taken : bus_a.taken;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard: got unexpected transaction expected none");
        end else begin
          e    = q.pop_front();
          a_pc = e.sel ? bus_b.pc : bus_a.pc;
          a_fl = e.sel ? bus_b.flags : bus_a.flags;
          a_d  = e.sel ? bus_b.stack_depth : bus_a.stack_depth;
          a_e  = e.sel ? bus_b.stack_err : bus_a.stack_err;
          if (e.chk_taken) chk(e.name, "taken", 32'(s_taken), 32'(e.taken));
          chk(e.name, "pc", a_pc, e.pc);
          chk(e.name, "flags", 32'(a_fl), 32'(e.flags));
          chk(e.name, "depth", 32'(a_d), 32'(e.depth));
          chk(e.name, "err", 32'(a_e), 32'(e.err));
          $display("txn %-12s dut=%s pc=%h flags=%b depth=%0d err=%0d taken=%0d",
                   e.name, e.sel ? "B" : "A", a_pc, a_fl, a_d, a_e, s_taken);
        end
      end
    end
  end

  initial begin
    int waited;
    bus_a.step = 0; bus_a.pc_control = 0; bus_a.offset = 0; bus_a.reg_target = 0;
    bus_a.flag_wren = 0; bus_a.alu_z = 0; bus_a.alu_c = 0; bus_a.alu_s = 0; bus_a.alu_v = 0;
    bus_b.step = 0; bus_b.pc_control = 0; bus_b.offset = 0; bus_b.reg_target = 0;
    bus_b.flag_wren = 0; bus_b.alu_z = 0; bus_b.alu_c = 0; bus_b.alu_s = 0; bus_b.alu_v = 0;
    repeat (2) @(negedge clk);

    // sel rst step ctl offset reg_target {fw,z,c,s,v} chk_taken taken pc flags depth err name
    vec(0, 1, 0, 4'd0,  26'd0,       32'h0,   5'b00000, 0, 0, 32'h100, 4'b0000, 6'd0, 0, "reset_a");
    vec(0, 0, 1, 4'd0,  26'd0,       32'h0,   5'b00000, 1, 0, 32'h104, 4'b0000, 6'd0, 0, "seq1");
    vec(0, 0, 1, 4'd0,  26'd0,       32'h0,   5'b00000, 1, 0, 32'h108, 4'b0000, 6'd0, 0, "seq2");
    vec(0, 0, 1, 4'd0,  26'd0,       32'h0,   5'b00000, 1, 0, 32'h10C, 4'b0000, 6'd0, 0, "seq3");
    vec(0, 0, 1, 4'd2,  26'd0,       32'h200, 5'b00000, 1, 1, 32'h200, 4'b0000, 6'd0, 0, "br_200");
    vec(0, 0, 1, 4'd1,  26'h3FFFFFE, 32'h0,   5'b00000, 1, 1, 32'h1FC, 4'b0000, 6'd0, 0, "b_neg2");
    vec(0, 0, 1, 4'd2,  26'd0,       32'h0,   5'b00000, 1, 1, 32'h0,   4'b0000, 6'd0, 0, "br_0");
    vec(0, 0, 1, 4'd1,  26'h3FFFFFF, 32'h0,   5'b00000, 1, 1, 32'h0,   4'b0000, 6'd0, 0, "b_neg1");
    vec(0, 0, 1, 4'd3,  26'd4,       32'h0,   5'b11000, 1, 0, 32'h4,   4'b1000, 6'd0, 0, "bz_hazard");
    vec(0, 0, 1, 4'd3,  26'd4,       32'h0,   5'b00000, 1, 1, 32'h18,  4'b1000, 6'd0, 0, "bz_taken");
    vec(0, 0, 1, 4'd0,  26'd0,       32'h0,   5'b10101, 1, 0, 32'h1C,  4'b0101, 6'd0, 0, "flag_wr");
    vec(0, 0, 1, 4'd4,  26'd1,       32'h0,   5'b00000, 1, 1, 32'h24,  4'b0101, 6'd0, 0, "bnz");
    vec(0, 0, 1, 4'd5,  26'd0,       32'h0,   5'b00000, 1, 1, 32'h28,  4'b0101, 6'd0, 0, "bcy");
    vec(0, 0, 1, 4'd6,  26'd5,       32'h0,   5'b00000, 1, 0, 32'h2C,  4'b0101, 6'd0, 0, "bncy");
    vec(0, 0, 1, 4'd7,  26'd5,       32'h0,   5'b00000, 1, 0, 32'h30,  4'b0101, 6'd0, 0, "bs");
    vec(0, 0, 1, 4'd8,  26'd2,       32'h0,   5'b00000, 1, 1, 32'h3C,  4'b0101, 6'd0, 0, "bns");
    vec(0, 0, 1, 4'd9,  26'd0,       32'h0,   5'b00000, 1, 1, 32'h40,  4'b0101, 6'd0, 0, "bv");
    vec(0, 0, 1, 4'd10, 26'd5,       32'h0,   5'b00000, 1, 0, 32'h44,  4'b0101, 6'd0, 0, "bnv");
    vec(0, 0, 1, 4'd2,  26'd0,       32'h40,  5'b00000, 1, 1, 32'h40,  4'b0101, 6'd0, 0, "br_40");
    vec(0, 0, 1, 4'd11, 26'd4,       32'h0,   5'b00000, 1, 1, 32'h54,  4'b0101, 6'd1, 0, "call");
    vec(0, 0, 1, 4'd12, 26'd0,       32'h0,   5'b00000, 1, 1, 32'h44,  4'b0101, 6'd0, 0, "ret");
    vec(0, 0, 0, 4'd1,  26'd9,       32'h0,   5'b11111, 1, 1, 32'h44,  4'b0101, 6'd0, 0, "stall");
    vec(0, 0, 1, 4'd13, 26'd9,       32'h0,   5'b00000, 1, 0, 32'h48,  4'b0101, 6'd0, 0, "code13");
    vec(0, 0, 1, 4'd14, 26'd9,       32'h0,   5'b00000, 1, 0, 32'h4C,  4'b0101, 6'd0, 0, "code14");
    vec(0, 0, 1, 4'd15, 26'd9,       32'h0,   5'b00000, 1, 0, 32'h50,  4'b0101, 6'd0, 0, "code15");
    vec(0, 0, 1, 4'd11, 26'd0,       32'h0,   5'b00000, 1, 1, 32'h54,  4'b0101, 6'd1, 0, "nest_c1");
    vec(0, 0, 1, 4'd11, 26'd2,       32'h0,   5'b00000, 1, 1, 32'h60,  4'b0101, 6'd2, 0, "nest_c2");
    vec(0, 0, 1, 4'd11, 26'h3FFFFF0, 32'h0,   5'b00000, 1, 1, 32'h24,  4'b0101, 6'd3, 0, "nest_c3");
    vec(0, 0, 1, 4'd12, 26'd0,       32'h0,   5'b00000, 1, 1, 32'h64,  4'b0101, 6'd2, 0, "nest_r3");
    vec(0, 0, 1, 4'd12, 26'd0,       32'h0,   5'b00000, 1, 1, 32'h58,  4'b0101, 6'd1, 0, "nest_r2");
    vec(0, 0, 1, 4'd12, 26'd0,       32'h0,   5'b00000, 1, 1, 32'h54,  4'b0101, 6'd0, 0, "nest_r1");
    vec(0, 0, 1, 4'd11, 26'd0,       32'h0,   5'b00000, 1, 1, 32'h58,  4'b0101, 6'd1, 0, "call_pre");
    vec(0, 1, 1, 4'd11, 26'd0,       32'h0,   5'b11111, 0, 0, 32'h100, 4'b0000, 6'd0, 0, "rst_mid");
    vec(0, 0, 1, 4'd2,  26'd0,       32'h103, 5'b00000, 1, 1, 32'h103, 4'b0000, 6'd0, 0, "br_unalign");

    vec(1, 1, 0, 4'd0,  26'd0,       32'h0,   5'b00000, 0, 0, 32'h0,   4'b0000, 6'd0, 0, "reset_b");
    vec(1, 0, 1, 4'd11, 26'd0,       32'h0,   5'b00000, 1, 1, 32'h4,   4'b0000, 6'd1, 0, "ovf_c1");
    vec(1, 0, 1, 4'd11, 26'd1,       32'h0,   5'b00000, 1, 1, 32'hC,   4'b0000, 6'd2, 0, "ovf_c2");
    vec(1, 0, 1, 4'd11, 26'd1,       32'h0,   5'b00000, 1, 1, 32'h14,  4'b0000, 6'd2, 1, "ovf_c3");
    vec(1, 0, 1, 4'd12, 26'd0,       32'h0,   5'b00000, 1, 1, 32'h8,   4'b0000, 6'd1, 1, "ovf_r1");
    vec(1, 0, 1, 4'd12, 26'd0,       32'h0,   5'b00000, 1, 1, 32'h4,   4'b0000, 6'd0, 1, "ovf_r2");
    vec(1, 0, 1, 4'd12, 26'd0,       32'h0,   5'b00000, 0, 0, 32'h8,   4'b0000, 6'd0, 1, "udf_r3");
    vec(1, 0, 1, 4'd0,  26'd0,       32'h0,   5'b00000, 1, 0, 32'hC,   4'b0000, 6'd0, 1, "err_sticky");
    vec(1, 1, 0, 4'd0,  26'd0,       32'h0,   5'b00000, 0, 0, 32'h0,   4'b0000, 6'd0, 0, "err_clear");

    @(negedge clk);
    vld = 1'b0;
    bus_a.step = 1'b0; bus_b.step = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
